pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator. It replaces the single-channel, externally counted PWM with:
- an internal prescaled period counter shared by all channels;
- per-channel mode, compare, and polarity settings;
- shadow (double-buffered) configuration that takes effect only at a period boundary, so outputs never glitch mid-period.

It sits between the peripheral register file and the top-level PWM pins.

## Interface
- CHANNELS, 4: number of PWM outputs (1..16).
- WIDTH, 16: counter/period/compare width in bits.
- PRE_W, 8: prescaler width in bits.
- clk  in  1  peripheral clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; low stops and clears the counter and forces all outputs low.
- prescale  in  PRE_W  counter advances once every prescale+1 clocks.
- period  in  WIDTH  counter runs 0..period inclusive; sampled at the update event.
- ch_en  in  CHANNELS  per-channel output enable; applied combinationally into the output register every cycle, with no shadowing.
- cfg_wr  in  1  one-cycle strobe that writes the staging registers of channel cfg_ch.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel; values >= CHANNELS are ignored.
- cfg_mode  in  2  00 left-aligned, 01 right-aligned, 10 unaligned, 11 forced inactive.
- cfg_inv  in  1  invert channel output.
- cfg_cmp1, cfg_cmp2  in  WIDTH  compare values.
- count_val  out  WIDTH  current counter value.
- period_end  out  1  one-cycle pulse after each counter wrap.
- pwm_out  out  CHANNELS  registered PWM outputs.

## Operation
- **Register sets:**
  - Staging set per channel: mode, inv, cmp1, cmp2, loaded only by cfg_wr.
  - Active set per channel, plus a single active period.
- **Prescaler** pc:
  - While en=1, pc counts 0..prescale; `tick` = (pc==prescale), and pc returns to 0 on tick.
  - While en=0, pc=0.
- **Counter** count_val:
  - On tick: count_val = period_act if count_val==period_act then 0, else count_val+1.
  - This is the wrap (update event).
  - While en=0, count_val=0.
- **Update event** (tick with count_val==period_act):
  - All active channel sets load from staging.
  - period_act loads from period.
  - These loads happen on the same edge the counter goes to 0.
- **While en=0:** active sets and period_act follow staging/period every cycle, so a restarted PWM uses the latest configuration from its first cycle.
- **Write/update collision:** if cfg_wr and the update event occur in the same cycle, active loads the pre-write staging value; the new write takes effect at the next wrap.
- **Channel function f** (evaluated on count_val and active set):
  - Left-aligned: count_val < cmp1.
  - Right-aligned: count_val >= cmp1.
  - Unaligned: cmp1 <= count_val < cmp2; constant 0 if cmp2 <= cmp1.
  - Mode 11: 0.
- **Output:** pwm_out[i] = en & ch_en[i] & (f ^ inv).
  - A disabled channel or en=0 gives 0, regardless of inv.
- **Edge values:**
  - Left-aligned, cmp1=0 → constant 0.
  - Left-aligned, cmp1 > period_act → constant 1.
  - Right-aligned, cmp1=0 → constant 1.
- **period_act=0:** counter stays 0; an update event and period_end occur on every tick.
- **Arithmetic:** all compares are unsigned WIDTH-bit; the counter never exceeds period_act.

## Timing
- Reset (async, immediate): pc, count_val, all staging/active registers, period_act, period_end, and pwm_out go to 0.
- Reset mid-period aborts the period; there is no partial completion.
- pwm_out[i] at edge t+1 reflects count_val, active set, en, and ch_en as they stand in cycle t (1-cycle latency).
- period_end is registered: it is high for exactly one clk in the cycle immediately after the wrap edge (first cycle with count_val=0 of the new period).
  - With prescale>0 it is not held for the remaining cycles at 0.
- After en rises (count_val=0, pc=0), the first increment occurs prescale+1 clocks later.
- Staging write: visible in staging the cycle after cfg_wr.
  - It reaches active at the next update event, or on the next edge if en=0.

## Test plan
- **Left-aligned:** CHANNELS=4, prescale=0, period=9, ch0 left cmp1=3, ch_en=1, en=1 → pwm_out[0] repeats 3 high / 7 low, lagging count_val by one cycle; period_end pulses every 10 clocks.
- **Unaligned and inverted:** ch1 unaligned cmp1=2, cmp2=6 → high for counts 2..5. Same channel with inv=1 → low for counts 2..5, high otherwise. ch2 unaligned cmp1=6, cmp2=2 → constant 0.
- **Shadow update:** running period=9, ch0 cmp1=3. Write cmp1=7 at count_val=4 → remainder of the current period still uses 3; the next period uses 7. Write exactly on the wrap cycle → 7 applies one period later.
- **Prescaler:** prescale=2, period=3 → each count_val value held 3 clocks; period_end pulses every 12 clocks, one clock wide.
- **Disable/reset:** deassert en mid-period → next cycle count_val=0, all pwm_out=0. Re-enable → first increment after prescale+1 clocks. Assert rst asynchronously mid-period → all outputs 0 without a clock edge.
- **Edge cases:** period=0 → period_end every tick, count_val=0. Left-aligned cmp1=0 → 0; cmp1=period+1 → constant 1. cfg_ch=CHANNELS → no register changes.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator with a shared prescaled period counter and
// double-buffered per-channel configuration.
//
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   en               global enable; low clears the counter and forces outputs low
//   prescale         counter advances once every prescale+1 clocks
//   period           counter runs 0..period; captured at each wrap (or every cycle while en=0)
//   ch_en            per-channel output enable, not shadowed
//   cfg_wr, cfg_ch   staging-register write strobe and target channel
//   cfg_mode         00 left, 01 right, 10 unaligned, 11 forced inactive
//   cfg_inv          output inversion
//   cfg_cmp1/2       compare values
//   count_val        current counter value
//   period_end       one-cycle pulse in the first cycle of each new period
//   pwm_out          registered PWM outputs
module pwm_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRE_W    = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [PRE_W-1:0]                              prescale,
    input  logic [WIDTH-1:0]                              period,
    input  logic [CHANNELS-1:0]                           ch_en,
    input  logic                                          cfg_wr,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [1:0]                                    cfg_mode,
    input  logic                                          cfg_inv,
    input  logic [WIDTH-1:0]                              cfg_cmp1,
    input  logic [WIDTH-1:0]                              cfg_cmp2,
    output logic [WIDTH-1:0]                              count_val,
    output logic                                          period_end,
    output logic [CHANNELS-1:0]                           pwm_out
);

    typedef struct packed {
        logic [1:0]       mode;
        logic             inv;
        logic [WIDTH-1:0] cmp1;
        logic [WIDTH-1:0] cmp2;
    } ch_cfg_t;

    logic [PRE_W-1:0]    pc_q, pc_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic                period_end_q, period_end_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    ch_cfg_t             stg_q [CHANNELS];
    ch_cfg_t             stg_d [CHANNELS];
    ch_cfg_t             act_q [CHANNELS];
    ch_cfg_t             act_d [CHANNELS];

    logic tick;
    logic wrap;
    logic load_act;
    logic f;

    always_comb begin
        tick         = en && (pc_q == prescale);
        wrap         = tick && (count_q == period_act_q);
        // Active set tracks staging while disabled so a restart uses the newest config.
        load_act     = !en || wrap;
        pc_d         = '0;
        count_d      = '0;
        period_end_d = wrap;
        period_act_d = load_act ? period : period_act_q;
        pwm_d        = '0;
        f            = 1'b0;

        if (en) begin
            if (tick) begin
                pc_d    = '0;
                count_d = wrap ? '0 : count_q + WIDTH'(1);
            end else begin
                pc_d    = pc_q + PRE_W'(1);
                count_d = count_q;
            end
        end

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Active loads the pre-write staging value on a write/wrap collision.
            act_d[i] = load_act ? stg_q[i] : act_q[i];
            stg_d[i] = stg_q[i];
            if (cfg_wr && (32'(cfg_ch) == i)) begin
                stg_d[i].mode = cfg_mode;
                stg_d[i].inv  = cfg_inv;
                stg_d[i].cmp1 = cfg_cmp1;
                stg_d[i].cmp2 = cfg_cmp2;
            end

            f = 1'b0;
            unique case (act_q[i].mode)
                2'b00:   f = count_q < act_q[i].cmp1;
                2'b01:   f = count_q >= act_q[i].cmp1;
                2'b10:   f = (count_q >= act_q[i].cmp1) && (count_q < act_q[i].cmp2);
                default: f = 1'b0;
            endcase
            pwm_d[i] = en && ch_en[i] && (f ^ act_q[i].inv);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= '0;
            count_q      <= '0;
            period_act_q <= '0;
            period_end_q <= 1'b0;
            pwm_q        <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                stg_q[i] <= '0;
                act_q[i] <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            count_q      <= count_d;
            period_act_q <= period_act_d;
            period_end_q <= period_end_d;
            pwm_q        <= pwm_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                stg_q[i] <= stg_d[i];
                act_q[i] <= act_d[i];
            end
        end
    end

    assign count_val  = count_q;
    assign period_end = period_end_q;
    assign pwm_out    = pwm_q;

endmodule
